// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared defaults and FSM encoding for the instruction fetch
// front-end.
//   WORD_SIZE_D / BLOCK_SIZE_D / BYTE_SIZE_D : default address, block and byte widths
//   fstate_t                                 : 2-bit fill FSM state encoding
package inst_fetch_pkg;
  localparam int WORD_SIZE_D  = 32;
  localparam int BLOCK_SIZE_D = 32;
  localparam int BYTE_SIZE_D  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CAPT  = 2'd3
  } fstate_t;
endpackage

// File: rtl/inst_fetch_line.sv
// fetch_line: the one-line, two-block instruction buffer.
//   clk, rst    : clock, async active-high reset
//   addr        : block-aligned fetch address
//   flush       : invalidate the line (wins over load)
//   load        : write base/d0/d1 and mark the line valid
//   load_base   : block-aligned address of d0
//   load_d0/d1  : block at load_base / load_base+B
//   hit         : addr is in the line (line valid, offset 0 or B)
//   blk         : selected block (meaningful only when hit)
module fetch_line #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 32,
  parameter int B          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_SIZE-1:0]  addr,
  input  logic                  flush,
  input  logic                  load,
  input  logic [WORD_SIZE-1:0]  load_base,
  input  logic [BLOCK_SIZE-1:0] load_d0,
  input  logic [BLOCK_SIZE-1:0] load_d1,
  output logic                  hit,
  output logic [BLOCK_SIZE-1:0] blk
);
  localparam int AW = $clog2(B);

  logic [WORD_SIZE-1:0]  base;
  logic [BLOCK_SIZE-1:0] d0, d1;
  logic                  line_valid;
  logic [WORD_SIZE-1:0]  off;

  // Modular subtraction: a line based at 2^W-B holds address 0 in d1.
  assign off = addr - base;
  assign hit = line_valid && (off == '0 || off == WORD_SIZE'(B));
  // On a hit the offset is 0 or B, so bit AW alone picks the block.
  assign blk = off[AW] ? d1 : d0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base       <= '0;
      d0         <= '0;
      d1         <= '0;
      line_valid <= 1'b0;
    end else if (flush) begin
      line_valid <= 1'b0;
    end else if (load) begin
      base       <= load_base;
      d0         <= load_d0;
      d1         <= load_d1;
      line_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch front-end between the CPU fetch stage and
// instruction memory. Serves blocks from a two-block line; on a miss issues
// one memory read, captures both returned blocks and stalls until filled.
//   clk, rst        : clock, async active-high reset
//   pc_in, req      : fetch byte address and request valid
//   flush           : invalidate line, abort any fill
//   inst/inst_valid : fetched block and its valid (combinational on hit)
//   stall           : request not served this cycle
//   mem_addr        : memory byte address (held between reads)
//   mem_readable    : one-cycle read enable per fill
//   mem_writable    : tied 0
//   mem_write       : tied 0
//   mem_out1/2      : memory blocks at mem_addr and mem_addr+B
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_D,
  parameter int BLOCK_SIZE = BLOCK_SIZE_D,
  parameter int BYTE_SIZE  = BYTE_SIZE_D,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_SIZE-1:0]  pc_in,
  input  logic                  req,
  input  logic                  flush,
  output logic [BLOCK_SIZE-1:0] inst,
  output logic                  inst_valid,
  output logic                  stall,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic                  mem_readable,
  output logic                  mem_writable,
  output logic [BLOCK_SIZE-1:0] mem_write,
  input  logic [BLOCK_SIZE-1:0] mem_out1,
  input  logic [BLOCK_SIZE-1:0] mem_out2
);
  localparam int B  = BLOCK_SIZE / BYTE_SIZE;
  localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

  fstate_t               state;
  logic [WORD_SIZE-1:0]  fill_addr;
  logic [CW-1:0]         cnt;
  logic [WORD_SIZE-1:0]  a;
  logic                  hit;
  logic [BLOCK_SIZE-1:0] blk;
  logic                  serve;

  assign a = pc_in & ~(WORD_SIZE'(B) - WORD_SIZE'(1));

  fetch_line #(
    .WORD_SIZE (WORD_SIZE),
    .BLOCK_SIZE(BLOCK_SIZE),
    .B         (B)
  ) u_line (
    .clk      (clk),
    .rst      (rst),
    .addr     (a),
    .flush    (flush),
    .load     (state == S_CAPT && !flush),
    .load_base(fill_addr),
    .load_d0  (mem_out1),
    .load_d1  (mem_out2),
    .hit      (hit),
    .blk      (blk)
  );

  assign serve        = req && hit && state == S_IDLE && !flush;
  assign inst         = serve ? blk : '0;
  assign inst_valid   = serve;
  assign stall        = req && !serve;
  assign mem_writable = 1'b0;
  assign mem_write    = '0;

  // mem_readable is raised on the IDLE->ISSUE edge so it is high exactly
  // for the ISSUE cycle; mem_addr is only loaded there and otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      fill_addr    <= '0;
      cnt          <= '0;
      mem_addr     <= '0;
      mem_readable <= 1'b0;
    end else if (flush) begin
      state        <= S_IDLE;
      mem_readable <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && !hit) begin
            fill_addr    <= a;
            mem_addr     <= a;
            mem_readable <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_readable <= 1'b0;
          cnt          <= '0;
          state        <= (MEM_LAT > 1) ? S_WAIT : S_CAPT;
        end
        S_WAIT: begin
          // WAIT spans MEM_LAT-1 cycles
          if (cnt == CW'(MEM_LAT - 2)) state <= S_CAPT;
          else                         cnt   <= cnt + CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, pc3;
  logic        req, req3, flush, flush3;
  logic [31:0] inst, inst3, maddr, maddr3, mw, mw3, mo1, mo2, mo13, mo23;
  logic        iv, iv3, st, st3, mrd, mrd3, mwe, mwe3;
  logic [7:0]  mem [256];
  int          n_chk = 0, n_fail = 0, pulses = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rdblk(input logic [31:0] ad);
    logic [7:0] i;
    i = ad[7:0];
    return {mem[i], mem[i + 8'd1], mem[i + 8'd2], mem[i + 8'd3]};
  endfunction

  // Combinational memory model: data follows the held mem_addr, so it is
  // valid whenever the DUT captures, regardless of latency.
  assign mo1  = rdblk(maddr);
  assign mo2  = rdblk(maddr + 32'd4);
  assign mo13 = rdblk(maddr3);
  assign mo23 = rdblk(maddr3 + 32'd4);

  always @(posedge clk) if (mrd) pulses++;

  inst_fetch #(.MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .pc_in(pc), .req(req), .flush(flush),
    .inst(inst), .inst_valid(iv), .stall(st), .mem_addr(maddr),
    .mem_readable(mrd), .mem_writable(mwe), .mem_write(mw),
    .mem_out1(mo1), .mem_out2(mo2));

  inst_fetch #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .pc_in(pc3), .req(req3), .flush(flush3),
    .inst(inst3), .inst_valid(iv3), .stall(st3), .mem_addr(maddr3),
    .mem_readable(mrd3), .mem_writable(mwe3), .mem_write(mw3),
    .mem_out1(mo13), .mem_out2(mo23));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    #4;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
    rst = 1'b1; req = 1'b0; pc = '0; flush = 1'b0;
    req3 = 1'b0; pc3 = '0; flush3 = 1'b0;

    // reset state
    tick(); req = 1'b1; mid();
    chk("rst_iv", 32'(iv), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_mrd", 32'(mrd), 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    chk("rst_stall", 32'(st), 32'd1);
    chk("rst_wr", {31'd0, mwe} | mw, 32'd0);
    req = 1'b0;
    tick(); rst = 1'b0; mid();
    chk("idle_stall", 32'(st), 32'd0);

    // cold miss
    tick(); req = 1'b1; pc = 32'h0; mid();
    chk("cold_c0_stall", 32'(st), 32'd1);
    chk("cold_c0_mrd", 32'(mrd), 32'd0);
    tick(); mid();
    chk("cold_c1_mrd", 32'(mrd), 32'd1);
    chk("cold_c1_maddr", maddr, 32'h0);
    chk("cold_c1_stall", 32'(st), 32'd1);
    tick(); mid();
    chk("cold_c2_mrd", 32'(mrd), 32'd0);
    chk("cold_c2_stall", 32'(st), 32'd1);
    chk("cold_c2_iv", 32'(iv), 32'd0);
    tick(); mid();
    chk("cold_c3_iv", 32'(iv), 32'd1);
    chk("cold_c3_inst", inst, 32'h11223344);
    chk("cold_c3_stall", 32'(st), 32'd0);
    tick(); pc = 32'h4; mid();
    chk("hit_d1_iv", 32'(iv), 32'd1);
    chk("hit_d1_inst", inst, 32'h55667788);
    // misaligned pc
    tick(); pc = 32'h6; mid();
    chk("mis_iv", 32'(iv), 32'd1);
    chk("mis_inst", inst, 32'h55667788);
    chk("mis_mrd", 32'(mrd), 32'd0);
    chk("pulses_1", 32'(pulses), 32'd1);

    // line replacement
    tick(); pc = 32'h8; mid();
    chk("rep_c0_stall", 32'(st), 32'd1);
    tick(); mid();
    chk("rep_c1_stall", 32'(st), 32'd1);
    chk("rep_c1_maddr", maddr, 32'h8);
    chk("rep_c1_mrd", 32'(mrd), 32'd1);
    tick(); mid();
    chk("rep_c2_stall", 32'(st), 32'd1);
    tick(); mid();
    chk("rep_c3_inst", inst, 32'h08090A0B);
    chk("rep_c3_iv", 32'(iv), 32'd1);
    tick(); pc = 32'h0; mid();
    chk("rep_old_miss", 32'(st), 32'd1);
    tick(); mid();
    chk("rep_old_maddr", maddr, 32'h0);
    tick(); tick(); mid();
    chk("rep_old_inst", inst, 32'h11223344);

    // wrap-around
    tick(); pc = 32'hFFFFFFFC; mid();
    chk("wrap_c0_stall", 32'(st), 32'd1);
    tick(); mid();
    chk("wrap_c1_maddr", maddr, 32'hFFFFFFFC);
    tick(); tick(); mid();
    chk("wrap_d0_inst", inst, 32'hFCFDFEFF);
    chk("wrap_d0_iv", 32'(iv), 32'd1);
    tick(); pc = 32'h0; mid();
    chk("wrap_d1_iv", 32'(iv), 32'd1);
    chk("wrap_d1_inst", inst, 32'h11223344);
    chk("wrap_pulses", 32'(pulses), 32'd4);

    // flush mid-fill
    tick(); pc = 32'h10; mid();
    chk("fl_c0_stall", 32'(st), 32'd1);
    tick(); flush = 1'b1; mid();
    chk("fl_c1_mrd", 32'(mrd), 32'd1);
    tick(); flush = 1'b0; pc = 32'h0; mid();
    chk("fl_line_inv", 32'(st), 32'd1);
    chk("fl_c2_mrd", 32'(mrd), 32'd0);
    chk("fl_c2_iv", 32'(iv), 32'd0);
    tick(); mid();
    chk("fl_refetch_mrd", 32'(mrd), 32'd1);
    chk("fl_refetch_maddr", maddr, 32'h0);
    tick(); tick(); mid();
    chk("fl_refill_inst", inst, 32'h11223344);
    chk("fl_pulses", 32'(pulses), 32'd6);
    // flush together with hit
    tick(); flush = 1'b1; mid();
    chk("flhit_iv", 32'(iv), 32'd0);
    chk("flhit_stall", 32'(st), 32'd1);
    tick(); flush = 1'b0; mid();
    chk("flhit_inv", 32'(st), 32'd1);
    req = 1'b0;

    // MEM_LAT = 3: miss-to-valid is 5 cycles
    tick(); req3 = 1'b1; pc3 = 32'h20; mid();
    chk("l3_c0_stall", 32'(st3), 32'd1);
    tick(); mid();
    chk("l3_c1_mrd", 32'(mrd3), 32'd1);
    chk("l3_c1_maddr", maddr3, 32'h20);
    tick(); mid();
    chk("l3_c2_mrd", 32'(mrd3), 32'd0);
    chk("l3_c2_stall", 32'(st3), 32'd1);
    tick(); mid();
    chk("l3_c3_stall", 32'(st3), 32'd1);
    tick(); mid();
    chk("l3_c4_stall", 32'(st3), 32'd1);
    tick(); mid();
    chk("l3_c5_iv", 32'(iv3), 32'd1);
    chk("l3_c5_inst", inst3, 32'h20212223);

    // reset mid-fill (async, in WAIT)
    tick(); pc3 = 32'h40; mid();
    tick(); mid();
    chk("rmf_maddr_pre", maddr3, 32'h40);
    tick(); #2 rst = 1'b1; #1;
    chk("rmf_maddr", maddr3, 32'h0);
    chk("rmf_mrd", 32'(mrd3), 32'd0);
    chk("rmf_iv", 32'(iv3), 32'd0);
    chk("rmf_stall", 32'(st3), 32'd1);
    tick(); rst = 1'b0; pc3 = 32'h20; mid();
    chk("rmf_line_inv", 32'(st3), 32'd1);
    chk("rmf_inst", inst3, 32'h0);
    req3 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end
endmodule
